fixed_silu_quantizer: RTL

//  Upstream feeder for the 7-bit SiLU lookup table. Converts a parallel stream of signed

---
 rtl/fixed_silu_quantizer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fixed_silu_quantizer.sv
`default_nettype none
// ============================================================================
// Module   : fixed_silu_quantizer
// Brief    : Two-stage round/saturate quantiser feeding the 7-bit SiLU table,
//            with a sticky saturation-event counter.
// Revision : 1.0
// ============================================================================
module fixed_silu_quantizer #(
    parameter int DATA_IN_0_PRECISION_0       = 16,
    parameter int DATA_IN_0_PRECISION_1       = 8,
    parameter int DATA_OUT_0_PRECISION_0      = 7,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
    parameter int SAT_CNT_WIDTH               = 16
) (
    input  logic                                                               clk,
    input  logic                                                               rst_n,
    input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PRECISION_0-1:0]       data_in_0,
    input  logic                                                               data_in_0_valid,
    output logic                                                               data_in_0_ready,
    output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_OUT_0_PRECISION_0-1:0]      data_out_0,
    output logic                                                               data_out_0_valid,
    input  logic                                                               data_out_0_ready,
    input  logic                                                               sat_clear,
    output logic [SAT_CNT_WIDTH-1:0]                                           sat_count
);

    localparam int c_IW = DATA_IN_0_PRECISION_0;
    localparam int c_IF = DATA_IN_0_PRECISION_1;
    localparam int c_OW = DATA_OUT_0_PRECISION_0;
    localparam int c_OF = DATA_OUT_0_PRECISION_1;
    localparam int c_P  = DATA_IN_0_PARALLELISM_DIM_0;
    localparam int c_SH = c_IF - c_OF;
    // Width of a rounded lane: the (IW+1)-bit sum after dropping SH bits.
    localparam int c_RW = c_IW + 1 - c_SH;

    localparam logic signed [c_RW-1:0]    c_MAX     = c_RW'((1 << (c_OW - 1)) - 1);
    localparam logic signed [c_RW-1:0]    c_MIN     = ~c_MAX;
    localparam logic [c_OW-1:0]           c_QMAX    = {1'b0, {(c_OW-1){1'b1}}};
    localparam logic [c_OW-1:0]           c_QMIN    = {1'b1, {(c_OW-1){1'b0}}};
    localparam logic [SAT_CNT_WIDTH-1:0]  c_CNT_MAX = '1;

    logic                     r_v1;
    logic                     r_v2;
    logic [c_P*c_RW-1:0]      r_s1;
    logic [c_P*c_OW-1:0]      r_out;
    logic [SAT_CNT_WIDTH-1:0] r_sat_cnt;

    logic [c_P*c_RW-1:0]      w_rnd;
    logic [c_P*c_OW-1:0]      w_q;
    logic [c_P-1:0]           w_sat_hi;
    logic [c_P-1:0]           w_sat_lo;
    logic                     w_any_sat;
    logic                     w_adv1;
    logic                     w_adv2;
    logic                     w_ld1;

    for (genvar gi = 0; gi < c_P; gi++) begin : g_lane
        logic signed [c_IW-1:0] w_x;
        logic signed [c_RW-1:0] w_r;

        assign w_x = data_in_0[gi*c_IW +: c_IW];

        if (c_SH > 0) begin : g_round
            localparam logic [c_IW:0] c_HALF = (c_IW + 1)'(1) << (c_SH - 1);
            logic signed [c_IW:0] w_sum;
            // One extra bit of headroom so the rounding add cannot overflow.
            assign w_sum = {w_x[c_IW-1], w_x} + c_HALF;
            assign w_rnd[gi*c_RW +: c_RW] = c_RW'(w_sum >>> c_SH);
        end else begin : g_pass
            assign w_rnd[gi*c_RW +: c_RW] = c_RW'({w_x[c_IW-1], w_x});
        end

        assign w_r          = r_s1[gi*c_RW +: c_RW];
        assign w_sat_hi[gi] = (w_r > c_MAX);
        assign w_sat_lo[gi] = (w_r < c_MIN);
        assign w_q[gi*c_OW +: c_OW] = w_sat_hi[gi] ? c_QMAX :
                                      w_sat_lo[gi] ? c_QMIN : w_r[c_OW-1:0];
    end

    assign w_any_sat       = |(w_sat_hi | w_sat_lo);
    assign w_adv2          = r_v2 & data_out_0_ready;
    // Stage 2 takes stage 1 whenever it is empty, so bubbles collapse.
    assign w_adv1          = r_v1 & (~r_v2 | w_adv2);
    assign data_in_0_ready = ~r_v1 | w_adv1;
    assign w_ld1           = data_in_0_valid & data_in_0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (w_ld1) begin
            r_v1 <= 1'b1;
            r_s1 <= w_rnd;
        end else if (w_adv1) begin
            r_v1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2  <= 1'b0;
            r_out <= '0;
        end else if (w_adv1) begin
            r_v2  <= 1'b1;
            r_out <= w_q;
        end else if (w_adv2) begin
            r_v2  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (sat_clear) begin
            r_sat_cnt <= '0;
        end else if (w_adv1 && w_any_sat && (r_sat_cnt != c_CNT_MAX)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign data_out_0       = r_out;
    assign data_out_0_valid = r_v2;
    assign sat_count        = r_sat_cnt;

endmodule
`default_nettype wire
